// File: rtl/instr_queue.sv
// Circular instruction FIFO between fetch and issue.
// Each entry holds {pc, instr}, and the oldest entry is presented combinationally at the head.
module instr_queue #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [31:0]              push_instr,
  input  logic [31:0]              push_pc,
  output logic                     full,
  input  logic                     instr_pop,
  output logic                     instr_valid,
  output logic [31:0]              head_instr,
  output logic [31:0]              head_pc,
  output logic [6:0]               opcode,
  output logic [6:0]               funct7,
  output logic [$clog2(DEPTH)-0:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: a push transfers when push && !full, and a pop transfers when
  // instr_pop && instr_valid. Flush cancels both in the same cycle.
  // full and instr_valid depend only on registered count, so they never follow inputs combinationally.

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_acc, pop_acc;

  assign full        = (count_q == CW'(DEPTH));
  assign instr_valid = (count_q != '0);
  assign count       = count_q;
  assign head_instr  = mem_q[head_q][31:0];
  assign head_pc     = mem_q[head_q][63:32];
  assign opcode      = head_instr[6:0];
  assign funct7      = head_instr[31:25];

  always_comb begin
    push_acc = push && !full && !flush;
    pop_acc  = instr_pop && instr_valid && !flush;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_acc) tail_d = tail_q + AW'(1);
      if (pop_acc)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(push_acc) - CW'(pop_acc);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_acc) mem_q[tail_q] <= {push_pc, push_instr};
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue.
// A queue-based reference model predicts count, the flags and the head entry after every edge.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        push;
  logic [31:0] push_instr;
  logic [31:0] push_pc;
  logic        full;
  logic        instr_pop;
  logic        instr_valid;
  logic [31:0] head_instr;
  logic [31:0] head_pc;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [4:0]  count;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  instr_queue #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push),
    .push_instr(push_instr), .push_pc(push_pc), .full(full),
    .instr_pop(instr_pop), .instr_valid(instr_valid),
    .head_instr(head_instr), .head_pc(head_pc), .opcode(opcode),
    .funct7(funct7), .count(count)
  );

  // Clock and input defaults
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    check({tag, ".valid"}, 64'(instr_valid), 64'(exp_q.size() != 0));
    check({tag, ".full"}, 64'(full), 64'(exp_q.size() == 16));
    if (exp_q.size() != 0) begin
      check({tag, ".head_pc"}, 64'(head_pc), 64'(exp_q[0][63:32]));
      check({tag, ".head_instr"}, 64'(head_instr), 64'(exp_q[0][31:0]));
      check({tag, ".opcode"}, 64'(opcode), 64'(exp_q[0][6:0]));
      check({tag, ".funct7"}, 64'(funct7), 64'(exp_q[0][31:25]));
    end
  endtask

  // Drives one cycle, updates the model, and checks the state after the edge.
  task automatic cycle(input string tag, input logic f, input logic p, input logic po,
                       input logic [31:0] pc, input logic [31:0] ins);
    flush = f; push = p; instr_pop = po; push_pc = pc; push_instr = ins;
    if (f) exp_q.delete();
    else begin
      logic do_push, do_pop;
      do_push = p && (exp_q.size() < 16);
      do_pop  = po && (exp_q.size() > 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, ins});
    end
    @(posedge clk); #1;
    flush = 1'b0; push = 1'b0; instr_pop = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; instr_pop = 1'b0;
    push_pc = '0; push_instr = '0;
    @(posedge clk); #1;
    do_reset();
    check("rst.count", 64'(count), 64'd0);
    check("rst.valid", 64'(instr_valid), 64'd0);
    check("rst.full", 64'(full), 64'd0);
    check("rst.head_pc", 64'(head_pc), 64'd0);
    check("rst.head_instr", 64'(head_instr), 64'd0);
    cycle("pop_empty", 0, 0, 1, 32'h0, 32'h0);
    check("pop_empty.count", 64'(count), 64'd0);

    // Fill to 16 entries, attempt a 17th push, then drain in order
    for (int i = 0; i < 16; i++)
      cycle("fill", 0, 1, 0, 32'h1000 + 32'(4 * i), 32'h13 + 32'(i));
    check("fill.count16", 64'(count), 64'd16);
    check("fill.full", 64'(full), 64'd1);
    cycle("push_full", 0, 1, 0, 32'h1040, 32'h13 + 32'd16);
    check("push_full.count", 64'(count), 64'd16);
    for (int i = 0; i < 16; i++) begin
      check("drain.order", 64'(head_pc), 64'(32'h1000 + 32'(4 * i)));
      cycle("drain", 0, 0, 1, 32'h0, 32'h0);
    end
    check("drain.empty", 64'(instr_valid), 64'd0);

    // Push and pop together while full: the pop is accepted and the push is dropped
    for (int i = 0; i < 16; i++)
      cycle("fill2", 0, 1, 0, 32'h5000 + 32'(4 * i), 32'h0000_0033 + 32'(i << 7));
    cycle("full_pp", 0, 1, 1, 32'h2000, 32'h0000_0063);
    check("full_pp.count", 64'(count), 64'd15);
    cycle("pp15", 0, 1, 1, 32'h2000, 32'h0000_0063);
    check("pp15.count", 64'(count), 64'd15);
    for (int i = 0; i < 14; i++) cycle("drain2", 0, 0, 1, 32'h0, 32'h0);
    check("drain2.tail_pc", 64'(head_pc), 64'h2000);
    cycle("drain2.last", 0, 0, 1, 32'h0, 32'h0);

    // Steady stream at count 3 so that both pointers wrap several times
    for (int i = 0; i < 3; i++)
      cycle("pre", 0, 1, 0, 32'h6000 + 32'(4 * i), 32'(i * 32'h0101_0101));
    for (int i = 0; i < 40; i++) begin
      cycle("stream", 0, 1, 1, 32'h7000 + 32'(4 * i), 32'($urandom_range(0, 32'hFFFF)) << 12 | 32'h17);
      check("stream.count3", 64'(count), 64'd3);
    end
    for (int i = 0; i < 3; i++) cycle("drain3", 0, 0, 1, 32'h0, 32'h0);

    // Flush takes priority over a same-cycle push and pop
    for (int i = 0; i < 5; i++)
      cycle("pre_flush", 0, 1, 0, 32'h8000 + 32'(4 * i), 32'h13);
    cycle("flush", 1, 1, 1, 32'h3000, 32'h0000_0013);
    check("flush.count", 64'(count), 64'd0);
    check("flush.valid", 64'(instr_valid), 64'd0);
    cycle("post_flush", 0, 1, 0, 32'h4000, 32'hABCD_E0B3);
    check("post_flush.pc", 64'(head_pc), 64'h4000);
    check("post_flush.opcode", 64'(opcode), 64'h33);
    check("post_flush.funct7", 64'(funct7), 64'h55);
    cycle("post_flush.pop", 0, 0, 1, 32'h0, 32'h0);

    // Reset during operation
    for (int i = 0; i < 7; i++)
      cycle("pre_rst", 0, 1, 0, 32'h9000 + 32'(4 * i), 32'hFFFF_FF00 + 32'(i));
    do_reset();
    check("mid_rst.count", 64'(count), 64'd0);
    check("mid_rst.valid", 64'(instr_valid), 64'd0);
    check("mid_rst.head_instr", 64'(head_instr), 64'd0);
    check("mid_rst.full", 64'(full), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
